// File: rtl/matmul_pkg.sv
// Shared types and constants for the Q7.9 matrix-multiply sequencer.
package matmul_pkg;

    localparam int INT_BITS  = 7;
    localparam int FRAC_BITS = 9;
    localparam int DATA_W    = INT_BITS + FRAC_BITS;
    localparam int N_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/matmul_seq_if.sv
// Job, operand-read, MAC and writeback signals of the sequencer.
interface matmul_seq_if
    import matmul_pkg::*;
#(
    parameter int N = N_DEF
);
    localparam int RW = $clog2(N);
    localparam int AW = 2 * RW;

    logic          start;
    logic          busy;
    logic          done;
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic          b_rd_en;
    logic [RW-1:0] b_rd_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          c_wr_valid;
    logic          c_wr_ready;
    logic [RW-1:0] c_wr_row;

    modport master (
        input  start, c_wr_ready,
        output busy, done, a_rd_en, a_rd_addr,
        output b_rd_en, b_rd_addr, mac_clr, mac_en,
        output c_wr_valid, c_wr_row
    );

    modport slave (
        output start, c_wr_ready,
        input  busy, done, a_rd_en, a_rd_addr,
        input  b_rd_en, b_rd_addr, mac_clr, mac_en,
        input  c_wr_valid, c_wr_row
    );

endinterface

// File: rtl/matmul_seq_ctrl_dly.sv
// Shift register that aligns {mac_clr, mac_en} with operand read data.
module seq_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                sr_q[s] <= '0;
            end
        end else begin
            sr_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) begin
                sr_q[s] <= sr_q[s-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Row-serial sequencer for C = A*B over an N-lane MAC row.
// Define MATMUL_SEQ_PERF_EN to add stall_cycles / job_cycles counters.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2,
    parameter int AW      = 2 * $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    matmul_seq_if.master bus
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  job_cycles
`endif
);

    localparam int RW = $clog2(N);
    localparam int LT = RD_LAT + MAC_LAT;
    localparam int CW = $clog2(LT + 1);

    localparam logic [RW-1:0] LAST     = RW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(LT - 1);

    seq_state_t    state_q, state_d;
    logic [RW-1:0] i_q, i_d;
    logic [RW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rd_en;
    logic          busy;
    logic          done;
    logic          wr_valid;
    logic [AW-1:0] a_addr;
    logic [RW-1:0] b_addr;
    logic [RW-1:0] wr_row;
    logic [1:0]    mac_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    i_d     = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST) begin
                    k_d     = '0;
                    cnt_d   = DRAIN_LD;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                if (bus.c_wr_ready) begin
                    if (i_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses and row index read as zero outside the state that uses them.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        rd_en    = (state_q == ISSUE);
        wr_valid = (state_q == WRITE);
        a_addr   = rd_en ? AW'({i_q, k_q}) : '0;
        b_addr   = rd_en ? k_q : '0;
        wr_row   = wr_valid ? i_q : '0;
    end

    seq_delay_line #(
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({rd_en && (k_q == '0), rd_en}),
        .q_o   (mac_q)
    );

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.a_rd_en    = rd_en;
    assign bus.a_rd_addr  = a_addr;
    assign bus.b_rd_en    = rd_en;
    assign bus.b_rd_addr  = b_addr;
    assign bus.mac_clr    = mac_q[1];
    assign bus.mac_en     = mac_q[0];
    assign bus.c_wr_valid = wr_valid;
    assign bus.c_wr_row   = wr_row;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] job_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            job_q   <= '0;
        end else if (state_q == IDLE && bus.start) begin
            stall_q <= '0;
            job_q   <= '0;
        end else begin
            if (wr_valid && !bus.c_wr_ready && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (busy && job_q != '1) begin
                job_q <= job_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign job_cycles   = job_q;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: N=16 defaults and an N=4 sweep.
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    logic start;
    logic ready;

    always #5 clk = ~clk;

    matmul_seq_if #(.N(16)) i16 ();
    matmul_seq_if #(.N(4))  i4 ();

    assign i16.start      = start & ~sel;
    assign i4.start       = start & sel;
    assign i16.c_wr_ready = ready | sel;
    assign i4.c_wr_ready  = ready | ~sel;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] st16, jb16, st4, jb4, m_st, m_jb;
`endif

    matmul_seq_ctrl #(.N(16), .RD_LAT(1), .MAC_LAT(2)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i16)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .stall_cycles (st16),
        .job_cycles   (jb16)
`endif
    );

    matmul_seq_ctrl #(.N(4), .RD_LAT(2), .MAC_LAT(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i4)
`ifdef MATMUL_SEQ_PERF_EN
        ,
        .stall_cycles (st4),
        .job_cycles   (jb4)
`endif
    );

    logic m_rd, m_en, m_clr, m_valid, m_done, m_busy;
    int   m_row, m_addr, m_b, m_k, m_lat, m_n;

    always_comb begin
        if (sel) begin
            m_rd = i4.a_rd_en; m_en = i4.mac_en; m_clr = i4.mac_clr;
            m_valid = i4.c_wr_valid; m_done = i4.done; m_busy = i4.busy;
            m_row = int'(i4.c_wr_row); m_addr = int'(i4.a_rd_addr);
            m_b = int'(i4.b_rd_addr); m_k = int'(i4.a_rd_addr[1:0]);
            m_lat = 2; m_n = 4;
        end else begin
            m_rd = i16.a_rd_en; m_en = i16.mac_en; m_clr = i16.mac_clr;
            m_valid = i16.c_wr_valid; m_done = i16.done; m_busy = i16.busy;
            m_row = int'(i16.c_wr_row); m_addr = int'(i16.a_rd_addr);
            m_b = int'(i16.b_rd_addr); m_k = int'(i16.a_rd_addr[3:0]);
            m_lat = 1; m_n = 16;
        end
`ifdef MATMUL_SEQ_PERF_EN
        m_st = sel ? st4 : st16;
        m_jb = sel ? jb4 : jb16;
`endif
    end

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int stall_row, stall_len;
    int n_rd, n_en, n_clr, n_hs, n_done, n_stall;
    int viol, row_err, lat_err, hs_exp, wcnt;
    int done_edge, first_rd, r3n, r3_first, r3_last, addr_err, r3_clr_ok;
    bit pend;
    logic [3:0] hen, hclr;

    // Sink model plus event counters, evaluated mid-cycle.
    always @(negedge clk) begin
        ready = !(m_valid && m_row == stall_row && wcnt < stall_len);
        if (!rst_n) begin
            hen = '0; hclr = '0; hs_exp = 0; wcnt = 0; pend = 0;
        end else begin
            if (m_rd) n_rd++;
            if (m_en) n_en++;
            if (m_clr) n_clr++;
            if (m_en !== hen[m_lat-1] || m_clr !== hclr[m_lat-1]) lat_err++;
            hen  = {hen[2:0], m_rd};
            hclr = {hclr[2:0], m_rd && m_k == 0};
            if (m_valid && ready) begin
                n_hs++;
                if (m_row != hs_exp) row_err++;
                hs_exp = (m_row == m_n - 1) ? 0 : m_row + 1;
            end
            if (m_valid && !ready) begin
                n_stall++;
                if (m_rd || m_en) viol++;
            end
            wcnt = (m_valid && !ready) ? wcnt + 1 : 0;
            if (m_done) begin
                n_done++; done_edge = edge_n; pend = 1;
            end else if (pend && m_rd) begin
                first_rd = edge_n; pend = 0;
            end
            if (!sel && m_rd && (m_addr >> 4) == 3) begin
                if (m_addr != 48 + r3n % 16 || m_b != r3n % 16 ||
                    (r3n % 16 != 0 && edge_n != r3_last + 1)) addr_err++;
                if (r3n % 16 == 0) r3_first = edge_n;
                r3_last = edge_n;
                r3n++;
            end
            if (!sel && m_clr && m_en && r3n > 0 && edge_n == r3_first + 1)
                r3_clr_ok++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit sel;
        int stall_row;
        int stall_len;
        bit poke;
        int exp_done;
        int exp_rd;
        int exp_en;
        int exp_clr;
        int exp_hs;
        int exp_stall;
    } vec_t;

    vec_t tbl[5];

    task automatic run_job(input vec_t v);
        int s_rd, s_en, s_clr, s_hs, s_dn, s_st, s_vi, s_re, s_le, s0;
        bit got;
        sel = v.sel; stall_row = v.stall_row; stall_len = v.stall_len;
        s_rd = n_rd; s_en = n_en; s_clr = n_clr; s_hs = n_hs;
        s_dn = n_done; s_st = n_stall; s_vi = viol;
        s_re = row_err; s_le = lat_err;
        @(negedge clk); #1 start = 1;
        @(negedge clk); #1 start = 0;
        s0 = edge_n;
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk); #1;
            start = v.poke && (edge_n - s0 == 50 || edge_n - s0 == 200);
            if (n_done != s_dn) got = 1;
        end
        start = 0;
        chk("job_finished", got, 1);
        chk("done_edge", done_edge - s0 + 1, v.exp_done);
        chk("done_pulses", n_done - s_dn, 1);
        chk("reads", n_rd - s_rd, v.exp_rd);
        chk("mac_en", n_en - s_en, v.exp_en);
        chk("mac_clr", n_clr - s_clr, v.exp_clr);
        chk("handshakes", n_hs - s_hs, v.exp_hs);
        chk("stall_seen", n_stall - s_st, v.exp_stall);
        chk("stall_side_fx", viol - s_vi, 0);
        chk("row_order", row_err - s_re, 0);
        chk("mac_align", lat_err - s_le, 0);
        @(negedge clk); #1;
        chk("busy_after_done", m_busy, 0);
        chk("done_one_cycle", m_done, 0);
`ifdef MATMUL_SEQ_PERF_EN
        chk("perf_stall", m_st, v.exp_stall);
        chk("perf_job", m_jb, v.exp_done);
`endif
    endtask

    initial begin
        int s0, sd;
        bit got;
        rst_n = 0; start = 0; sel = 0;
        stall_row = -1; stall_len = 0;

        tbl[0] = '{sel:0, stall_row:-1, stall_len:0, poke:0, exp_done:321,
                   exp_rd:256, exp_en:256, exp_clr:16, exp_hs:16, exp_stall:0};
        tbl[1] = '{sel:0, stall_row:5, stall_len:7, poke:0, exp_done:328,
                   exp_rd:256, exp_en:256, exp_clr:16, exp_hs:16, exp_stall:7};
        tbl[2] = '{sel:0, stall_row:-1, stall_len:0, poke:1, exp_done:321,
                   exp_rd:256, exp_en:256, exp_clr:16, exp_hs:16, exp_stall:0};
        tbl[3] = '{sel:1, stall_row:-1, stall_len:0, poke:0, exp_done:33,
                   exp_rd:16, exp_en:16, exp_clr:4, exp_hs:4, exp_stall:0};
        tbl[4] = '{sel:1, stall_row:2, stall_len:3, poke:0, exp_done:36,
                   exp_rd:16, exp_en:16, exp_clr:4, exp_hs:4, exp_stall:3};

        #23;
        chk("reset_outs16", {i16.busy, i16.done, i16.a_rd_en, i16.b_rd_en,
            i16.mac_clr, i16.mac_en, i16.c_wr_valid, i16.a_rd_addr,
            i16.b_rd_addr, i16.c_wr_row}, 0);
        chk("reset_outs4", {i4.busy, i4.done, i4.a_rd_en, i4.mac_en,
            i4.c_wr_valid, i4.a_rd_addr, i4.c_wr_row}, 0);
        @(negedge clk); rst_n = 1;

        for (int j = 0; j < 5; j++) begin
            run_job(tbl[j]);
            if (j == 0) begin
                chk("row3_reads", r3n, 16);
                chk("row3_addr_seq", addr_err, 0);
                chk("row3_clr_align", r3_clr_ok, 1);
            end
        end

        // start held high across DONE restarts right after the IDLE cycle
        sel = 0; stall_row = -1; stall_len = 0;
        sd = n_done; got = 0;
        @(negedge clk); #1 start = 1;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk); #1;
            if (n_done != sd) got = 1;
        end
        chk("held_first_done", got, 1);
        for (int c = 0; c < 5 && pend; c++) begin
            @(negedge clk); #1;
        end
        start = 0;
        chk("held_restart_gap", first_rd - done_edge, 2);
        sd = n_done; got = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk); #1;
            if (n_done != sd) got = 1;
        end
        chk("held_second_done", got, 1);

        // asynchronous reset in the DRAIN of row 9
        @(negedge clk); #1 start = 1;
        @(negedge clk); #1 start = 0;
        s0 = edge_n; sd = n_done;
        for (int c = 0; c < 400 && edge_n - s0 < 196; c++) @(negedge clk);
        chk("drain_mac_inflight", i16.mac_en, 1);
        chk("drain_no_read", i16.a_rd_en, 0);
        #2 rst_n = 0;
        #1;
        chk("midrst_outs", {i16.busy, i16.done, i16.a_rd_en, i16.b_rd_en,
            i16.mac_clr, i16.mac_en, i16.c_wr_valid, i16.a_rd_addr,
            i16.b_rd_addr, i16.c_wr_row}, 0);
        repeat (3) @(negedge clk);
        chk("midrst_hold", {i16.busy, i16.mac_en, i16.done}, 0);
        chk("midrst_no_done", n_done - sd, 0);
`ifdef MATMUL_SEQ_PERF_EN
        chk("midrst_perf", {st16, jb16}, 0);
`endif
        rst_n = 1;
        run_job(tbl[0]);
        chk("row_order_total", row_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
